// File: rtl/adc_sample_averager_if.sv
// Sample-strobe and OPB slave signals of the ADC sample averager.
// The bench or upstream logic drives the master side. The averager takes the slave side.
interface adc_sample_averager_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] smp_data;
    logic                smp_valid;
    logic [31:0]         opb_addr;
    logic [31:0]         opb_di;
    logic                opb_we;
    logic                opb_re;
    logic [31:0]         opb_do;
    logic                avg_irq;

    modport master (
        output smp_data, smp_valid, opb_addr, opb_di, opb_we, opb_re,
        input  opb_do, avg_irq
    );

    modport slave (
        input  smp_data, smp_valid, opb_addr, opb_di, opb_we, opb_re,
        output opb_do, avg_irq
    );
endinterface

// File: rtl/adc_sample_averager.sv
// Decimating boxcar averager. Blocks of 2^k samples are averaged into a word FIFO,
// and an OPB register file gives software access to the FIFO, status, raw min/max and a level IRQ.
module adc_sample_averager #(
    parameter int SAMPLE_W  = 16,
    parameter int MAX_SHIFT = 6,
    parameter int FIFO_AW   = 6
) (
    input  logic                 opb_clk_i,
    input  logic                 opb_rst_n_i,
    adc_sample_averager_if.slave bus_if
);
    localparam int ACC_W = SAMPLE_W + MAX_SHIFT;
    localparam int CNT_W = MAX_SHIFT + 1;
    localparam int SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int LVL_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [11:0] A_CTRL    = 12'h000;
    localparam logic [11:0] A_SHIFT   = 12'h002;
    localparam logic [11:0] A_IRQ_LVL = 12'h004;
    localparam logic [11:0] A_STATUS  = 12'h006;
    localparam logic [11:0] A_FIFO    = 12'h008;
    localparam logic [11:0] A_MINMAX  = 12'h00A;

    logic                enable_q, enable_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic [LVL_W-1:0]    irq_lvl_q, irq_lvl_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] min_q, min_d, max_q, max_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic [31:0]         opb_do_q, opb_do_d;
    logic                irq_q, irq_d;

    logic [SAMPLE_W-1:0] mem [DEPTH];

    logic [11:0]         addr_w;
    logic                wr_ctrl_w, wr_shift_w, wr_lvl_w, rd_fifo_w;
    logic                clear_w, discard_w, take_w, blk_done_w;
    logic                fifo_empty_w, fifo_full_w, pop_w, push_w;
    logic [ACC_W-1:0]    sum_w;
    logic [CNT_W-1:0]    cnt_inc_w;
    logic [SAMPLE_W-1:0] avg_w;
    logic [SH_W-1:0]     shift_wr_w;
    logic [31:0]         status_w;
    logic                unused_ok;

    assign addr_w     = bus_if.opb_addr[11:0];
    assign wr_ctrl_w  = bus_if.opb_we && (addr_w == A_CTRL);
    assign wr_shift_w = bus_if.opb_we && (addr_w == A_SHIFT);
    assign wr_lvl_w   = bus_if.opb_we && (addr_w == A_IRQ_LVL);
    assign rd_fifo_w  = bus_if.opb_re && (addr_w == A_FIFO);
    assign clear_w    = wr_ctrl_w && bus_if.opb_di[1];
    assign shift_wr_w = bus_if.opb_di[SH_W-1:0];

    // Dropping ENABLE or retuning k invalidates whatever partial block is in flight.
    assign discard_w  = wr_shift_w || (wr_ctrl_w && enable_q && !bus_if.opb_di[0]);
    assign take_w     = bus_if.smp_valid && enable_q && !clear_w && !discard_w;

    assign sum_w      = acc_q + ACC_W'(bus_if.smp_data);
    assign cnt_inc_w  = cnt_q + CNT_W'(1);
    assign blk_done_w = take_w && (cnt_inc_w == (CNT_W'(1) << shift_q));
    assign avg_w      = SAMPLE_W'(sum_w >> shift_q);

    assign fifo_empty_w = (level_q == '0);
    assign fifo_full_w  = (level_q == LVL_W'(DEPTH));
    assign pop_w        = rd_fifo_w && !fifo_empty_w;
    // A same-cycle pop frees the slot the new word needs.
    assign push_w       = blk_done_w && (!fifo_full_w || pop_w);

    assign unused_ok = ^{bus_if.opb_addr[31:12], bus_if.opb_di[31:LVL_W]};

    always_comb begin
        status_w = '0;
        status_w[LVL_W-1:0] = level_q;
        status_w[8]  = fifo_empty_w;
        status_w[9]  = fifo_full_w;
        status_w[10] = ovf_q;
        status_w[11] = udf_q;
    end

    always_comb begin
        enable_d  = wr_ctrl_w ? bus_if.opb_di[0] : enable_q;
        shift_d   = shift_q;
        irq_lvl_d = irq_lvl_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        opb_do_d  = opb_do_q;
        irq_d     = (irq_lvl_q != '0) && (level_q >= irq_lvl_q);

        if (wr_shift_w)
            shift_d = (shift_wr_w > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : shift_wr_w;
        if (wr_lvl_w)
            irq_lvl_d = bus_if.opb_di[LVL_W-1:0];

        if (clear_w || discard_w) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take_w) begin
            acc_d = blk_done_w ? '0 : sum_w;
            cnt_d = blk_done_w ? '0 : cnt_inc_w;
        end

        if (take_w) begin
            if (bus_if.smp_data < min_q) min_d = bus_if.smp_data;
            if (bus_if.smp_data > max_q) max_d = bus_if.smp_data;
        end

        if (clear_w) begin
            min_d    = '1;
            max_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_w) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (pop_w)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            level_d = level_q + LVL_W'(push_w) - LVL_W'(pop_w);
            if (blk_done_w && !push_w)         ovf_d = 1'b1;
            if (rd_fifo_w && fifo_empty_w)     udf_d = 1'b1;
        end

        if (bus_if.opb_re) begin
            case (addr_w)
                A_CTRL:    opb_do_d = 32'(enable_q);
                A_SHIFT:   opb_do_d = 32'(shift_q);
                A_IRQ_LVL: opb_do_d = 32'(irq_lvl_q);
                A_STATUS:  opb_do_d = status_w;
                A_FIFO:    opb_do_d = fifo_empty_w ? 32'h0 : 32'(mem[rd_ptr_q]);
                A_MINMAX:  opb_do_d = {max_q, min_q};
                default:   opb_do_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge opb_clk_i or negedge opb_rst_n_i) begin
        if (!opb_rst_n_i) begin
            enable_q  <= 1'b0;
            shift_q   <= '0;
            irq_lvl_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            opb_do_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            shift_q   <= shift_d;
            irq_lvl_q <= irq_lvl_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            opb_do_q  <= opb_do_d;
            irq_q     <= irq_d;
        end
    end

    // Storage carries no reset so it maps onto block RAM; occupancy lives in the pointers.
    always_ff @(posedge opb_clk_i) begin
        if (push_w)
            mem[wr_ptr_q] <= avg_w;
    end

    assign bus_if.opb_do  = opb_do_q;
    assign bus_if.avg_irq = irq_q;
endmodule
